pulse_burst_scheduler: RTL and testbench
========================================

# pulse_burst_scheduler

Sequences the transmit side of the send_signal path. On a start request it emits a burst of N pulses on `tx_out`, each with a programmable period and high time, followed by a fixed guard interval. It also produces a per-pulse sync strobe for the receive-side timing logic, plus busy, done and error flags for the top-level controller. Configuration is sampled at start, so the controller may change the inputs while a burst runs.

## Interface
- `PERIOD_MAX`, 1024: largest legal period and high time, in clock cycles. `PW = $clog2(PERIOD_MAX+1)`.
- `COUNT_MAX`, 64: largest legal pulses per burst. `NW = $clog2(COUNT_MAX+1)`.
- `GUARD_CYCLES`, 8: cycles of forced-low `tx_out` with busy held, after the last pulse. 0 is legal.

Ports:
- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  burst request; sampled only in IDLE.
- `abort_in`  in  1  terminates any burst in progress.
- `num_pulses_in`  in  NW  pulses per burst, 1..COUNT_MAX.
- `period_in`  in  PW  cycles per pulse, 2..PERIOD_MAX.
- `high_in`  in  PW  high cycles per pulse, 1..period_in-1.
- `tx_out`  out  1  registered pulse train to the emitter driver.
- `pulse_out`  out  1  one-cycle strobe, coincident with the first high cycle of each pulse.
- `pulse_idx_out`  out  NW  index of the current pulse (0-based); holds its value after the burst.
- `busy_out`  out  1  high from the first pulse cycle through the last guard cycle.
- `done_out`  out  1  one-cycle strobe when a burst completes normally.
- `err_out`  out  1  one-cycle strobe when a start request is rejected.

## Operation
- States: IDLE, HIGH, LOW, GUARD.
- All outputs are registered. Internal counters: `phase_cnt` (PW bits, 0..period-1), `pulse_cnt` (NW bits), `guard_cnt`.
- **Start in IDLE.** `start_in`=1 and `abort_in`=0 → validate the inputs.
  - Valid means: `num_pulses_in` in 1..COUNT_MAX; `period_in` in 2..PERIOD_MAX; `high_in` ≥ 1; `high_in` < `period_in`.
  - Valid → latch the config, clear the counters, go to HIGH.
  - Invalid → stay IDLE and pulse `err_out`.
- **HIGH.** `tx_out`=1. `pulse_out`=1 only in the first cycle. `phase_cnt` increments each cycle. When `phase_cnt`==high-1, go to LOW.
- **LOW.** `tx_out`=0. When `phase_cnt`==period-1:
  - `phase_cnt` → 0.
  - If `pulse_cnt`==N-1: go to GUARD, or straight to IDLE with `done_out` if GUARD_CYCLES=0.
  - Otherwise: increment `pulse_cnt`, go to HIGH.
- **GUARD.** `tx_out`=0. After GUARD_CYCLES cycles, go to IDLE and assert `done_out`.
- **Abort.** `abort_in`=1 in any non-IDLE state → next cycle is IDLE with `tx_out`=0 and `busy_out`=0. No `done_out` and no `err_out`. The counters keep their values.
- **Simultaneous events.**
  - `start_in` and `abort_in` together in IDLE: abort wins, no start, no error.
  - `start_in` while busy: ignored, no error.
  - `start_in` held high in the cycle `done_out` is asserted: accepted, and the next burst's HIGH begins the cycle after.
- **Mid-burst input changes.** Changes on the config inputs have no effect until the next accepted start.
- **Reset.** `rst_n_in` low forces, asynchronously and from any state:
  - state IDLE;
  - `tx_out`, `pulse_out`, `busy_out`, `done_out`, `err_out` all 0;
  - `pulse_idx_out` and all counters 0.

## Timing
- Call E0 the edge that samples a valid start. Cycle k is the cycle following edge Ek-1.
- `tx_out`, `pulse_out` and `busy_out` rise in cycle 1, i.e. one cycle of latency.
- Pulse p (0-based) is high in cycles 1+p·P through p·P+H. P is the period and H the high time.
- `pulse_idx_out` equals p from cycle 1+p·P onward.
- `busy_out` is high for exactly N·P+GUARD_CYCLES cycles.
- `done_out` is high in cycle N·P+GUARD_CYCLES+1, and `busy_out` is 0 in that cycle.
- `err_out` is high in the cycle after the rejected request.
- Abort sampled at edge Ea → all outputs idle in cycle a+1.
- Minimum burst: N=1, P=2, H=1, GUARD_CYCLES=0 → busy for 2 cycles, done in cycle 3.

## Test plan
- **Basic burst.** GUARD_CYCLES=2; N=3, P=4, H=1; start at E0.
  - `tx_out` high in cycles 1, 5 and 9 only.
  - `pulse_out` high in the same cycles.
  - `pulse_idx_out` reads 0, 1, 2.
  - `busy_out` high in cycles 1–14.
  - `done_out` high in cycle 15 only.
- **Invalid config rejected.**
  - P=4, H=4 → `err_out` in cycle 1, `busy_out` stays 0, `tx_out` stays 0.
  - N=0 → same response.
- **Abort and start collisions.**
  - Abort at E6 during the basic burst → cycle 7 idle, no `done_out`.
  - Start and abort together in IDLE → nothing happens.
- **Config stability and back-to-back bursts.**
  - Change `period_in` to 8 during the basic burst → burst timing unchanged.
  - Start held high through `done_out` → second burst's `tx_out` rises in cycle 16.
- **Asynchronous reset.** Assert `rst_n_in` mid-HIGH, between edges → `tx_out` and `busy_out` drop before the next edge. After release, state is IDLE and a new start is accepted normally.
- **Boundary values.**
  - N=1, P=2, H=1, GUARD_CYCLES=0 → `tx_out` high in cycle 1, `done_out` in cycle 3.
  - N=COUNT_MAX, P=PERIOD_MAX, H=PERIOD_MAX-1 → `pulse_idx_out` ends at COUNT_MAX-1 with no counter wrap.

Source files
------------

// File: rtl/pulse_burst_scheduler_if.sv
// Control/config and status bundle between the burst controller and pulse_burst_scheduler.
interface pulse_burst_scheduler_if #(
    parameter int unsigned PERIOD_MAX = 1024,
    parameter int unsigned COUNT_MAX  = 64
) ();
    localparam int unsigned PW = $clog2(PERIOD_MAX + 1);
    localparam int unsigned NW = $clog2(COUNT_MAX + 1);

    logic          start_in;
    logic          abort_in;
    logic [NW-1:0] num_pulses_in;
    logic [PW-1:0] period_in;
    logic [PW-1:0] high_in;
    logic          tx_out;
    logic          pulse_out;
    logic [NW-1:0] pulse_idx_out;
    logic          busy_out;
    logic          done_out;
    logic          err_out;

    modport master (
        output start_in, abort_in, num_pulses_in, period_in, high_in,
        input  tx_out, pulse_out, pulse_idx_out, busy_out, done_out, err_out
    );

    modport slave (
        input  start_in, abort_in, num_pulses_in, period_in, high_in,
        output tx_out, pulse_out, pulse_idx_out, busy_out, done_out, err_out
    );
endinterface

// File: rtl/pulse_burst_scheduler.sv
// Transmit burst sequencer: N pulses of programmable period/high time, then a guard interval.
// Config is latched at an accepted start; all outputs are registered.
module pulse_burst_scheduler #(
    parameter int unsigned PERIOD_MAX   = 1024,
    parameter int unsigned COUNT_MAX    = 64,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input logic                    clk_in,
    input logic                    rst_n_in,
    pulse_burst_scheduler_if.slave bus_io
);
    localparam int unsigned PW = $clog2(PERIOD_MAX + 1);
    localparam int unsigned NW = $clog2(COUNT_MAX + 1);
    localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GuardLast = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StGuard} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [NW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic [NW-1:0] num_q, num_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] high_q, high_d;
    logic          tx_q, tx_d;
    logic          strobe_q, strobe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cfg_ok;

    assign cfg_ok = (bus_io.num_pulses_in != '0)
                 && (bus_io.num_pulses_in <= NW'(COUNT_MAX))
                 && (bus_io.period_in >= PW'(2))
                 && (bus_io.period_in <= PW'(PERIOD_MAX))
                 && (bus_io.high_in != '0)
                 && (bus_io.high_in < bus_io.period_in);

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        guard_cnt_d = guard_cnt_q;
        num_d       = num_q;
        period_d    = period_q;
        high_d      = high_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start_in && !bus_io.abort_in) begin
                    if (cfg_ok) begin
                        num_d       = bus_io.num_pulses_in;
                        period_d    = bus_io.period_in;
                        high_d      = bus_io.high_in;
                        phase_cnt_d = '0;
                        pulse_cnt_d = '0;
                        guard_cnt_d = '0;
                        state_d     = StHigh;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHigh: begin
                phase_cnt_d = phase_cnt_q + PW'(1);
                if (phase_cnt_q == high_q - PW'(1)) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_cnt_q == period_q - PW'(1)) begin
                    phase_cnt_d = '0;
                    if (pulse_cnt_q == num_q - NW'(1)) begin
                        if (GUARD_CYCLES == 0) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            guard_cnt_d = '0;
                            state_d     = StGuard;
                        end
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + NW'(1);
                        state_d     = StHigh;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + PW'(1);
                end
            end
            StGuard: begin
                if (guard_cnt_q == GuardLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort freezes the counters where they are and suppresses any completion.
        if (state_q != StIdle && bus_io.abort_in) begin
            state_d     = StIdle;
            phase_cnt_d = phase_cnt_q;
            pulse_cnt_d = pulse_cnt_q;
            guard_cnt_d = guard_cnt_q;
            done_d      = 1'b0;
        end

        tx_d     = (state_d == StHigh);
        strobe_d = (state_d == StHigh) && (state_q != StHigh);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            pulse_cnt_q <= '0;
            guard_cnt_q <= '0;
            num_q       <= '0;
            period_q    <= '0;
            high_q      <= '0;
            tx_q        <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            num_q       <= num_d;
            period_q    <= period_d;
            high_q      <= high_d;
            tx_q        <= tx_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.tx_out        = tx_q;
    assign bus_io.pulse_out     = strobe_q;
    assign bus_io.pulse_idx_out = pulse_cnt_q;
    assign bus_io.busy_out      = busy_q;
    assign bus_io.done_out      = done_q;
    assign bus_io.err_out       = err_q;
endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: a default instance (guard 2) and a small one (guard 0)
// checked cycle by cycle against an arithmetic model of the burst waveform.
module tb_pulse_burst_scheduler;
    localparam int unsigned PMAX_A = 1024;
    localparam int unsigned CMAX_A = 64;
    localparam int unsigned GUARD_A = 2;
    localparam int unsigned PMAX_B = 16;
    localparam int unsigned CMAX_B = 8;
    localparam int unsigned GUARD_B = 0;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    pulse_burst_scheduler_if #(.PERIOD_MAX(PMAX_A), .COUNT_MAX(CMAX_A)) if_a ();
    pulse_burst_scheduler_if #(.PERIOD_MAX(PMAX_B), .COUNT_MAX(CMAX_B)) if_b ();

    pulse_burst_scheduler #(
        .PERIOD_MAX(PMAX_A), .COUNT_MAX(CMAX_A), .GUARD_CYCLES(GUARD_A)
    ) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .bus_io(if_a.slave)
    );

    pulse_burst_scheduler #(
        .PERIOD_MAX(PMAX_B), .COUNT_MAX(CMAX_B), .GUARD_CYCLES(GUARD_B)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .bus_io(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {tx, pulse, busy, done, err, idx[7:0]} in cycle k after the accepting edge.
    function automatic logic [12:0] model(int k, int n, int p, int h, int g);
        logic tx = 1'b0;
        logic pl = 1'b0;
        logic busy = 1'b0;
        logic done = 1'b0;
        int   idx = n - 1;
        if (k >= 1 && k <= n * p) begin
            idx  = (k - 1) / p;
            tx   = ((k - 1) % p) < h;
            pl   = ((k - 1) % p) == 0;
            busy = 1'b1;
        end else if (k > n * p && k <= n * p + g) begin
            busy = 1'b1;
        end else if (k == n * p + g + 1) begin
            done = 1'b1;
        end
        return {tx, pl, busy, done, 1'b0, 8'(idx)};
    endfunction

    function automatic logic cfg_valid(int n, int p, int h, int pmax, int cmax);
        return (n >= 1) && (n <= cmax) && (p >= 2) && (p <= pmax) && (h >= 1) && (h < p);
    endfunction

    function automatic logic [12:0] obs_a();
        return {if_a.tx_out, if_a.pulse_out, if_a.busy_out, if_a.done_out, if_a.err_out,
                8'(if_a.pulse_idx_out)};
    endfunction

    function automatic logic [12:0] obs_b();
        return {if_b.tx_out, if_b.pulse_out, if_b.busy_out, if_b.done_out, if_b.err_out,
                8'(if_b.pulse_idx_out)};
    endfunction

    task automatic drive_a(int n, int p, int h, logic s, logic ab);
        if_a.num_pulses_in = 7'(n);
        if_a.period_in     = 11'(p);
        if_a.high_in       = 11'(h);
        if_a.start_in      = s;
        if_a.abort_in      = ab;
    endtask

    task automatic drive_b(int n, int p, int h, logic s, logic ab);
        if_b.num_pulses_in = 4'(n);
        if_b.period_in     = 5'(p);
        if_b.high_in       = 5'(h);
        if_b.start_in      = s;
        if_b.abort_in      = ab;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(0, 0, 0, 1'b0, 1'b0);
        drive_b(0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_assert++;
        if (obs_a() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %b want %b", obs_a(), 13'd0);
        end
        n_assert++;
        if (obs_b() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %b want %b", obs_b(), 13'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [12:0] exp;
        drive_a(3, 4, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if_a.start_in = 1'b0;
            // Config moves mid-burst must not disturb the latched timing.
            if (k == 3) if_a.period_in = 11'd8;
            if (k == 6) if_a.high_in = 11'd3;
            exp = model(k, 3, 4, 1, GUARD_A);
            n_assert++;
            if (obs_a() !== exp) begin
                n_fail++;
                $display("FAIL basic cyc %0d: got %b want %b", k, obs_a(), exp);
            end
        end
    endtask

    task automatic test_invalid();
        int tn[6] = '{3, 0, 3, 3, 3, 65};
        int tp[6] = '{4, 4, 1, 4, 1025, 4};
        int th[6] = '{4, 1, 1, 0, 1, 1};
        logic [2:0] exp;
        logic [2:0] got;
        for (int i = 0; i < 6; i++) begin
            drive_a(tn[i], tp[i], th[i], 1'b1, 1'b0);
            @(negedge clk);
            if_a.start_in = 1'b0;
            exp = {2'b00, !cfg_valid(tn[i], tp[i], th[i], PMAX_A, CMAX_A)};
            got = {if_a.tx_out, if_a.busy_out, if_a.err_out};
            n_assert++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL invalid_a %0d: got tx/busy/err %b want %b", i, got, exp);
            end
            @(negedge clk);
            n_assert++;
            if (if_a.err_out !== 1'b0 || if_a.busy_out !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_a_clear %0d: got err %b busy %b want 0 0", i,
                         if_a.err_out, if_a.busy_out);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive_b(9, 4, 1, 1'b1, 1'b0);
            else        drive_b(2, 17, 1, 1'b1, 1'b0);
            @(negedge clk);
            if_b.start_in = 1'b0;
            exp = (i == 0) ? {2'b00, !cfg_valid(9, 4, 1, PMAX_B, CMAX_B)}
                           : {2'b00, !cfg_valid(2, 17, 1, PMAX_B, CMAX_B)};
            got = {if_b.tx_out, if_b.busy_out, if_b.err_out};
            n_assert++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL invalid_b %0d: got tx/busy/err %b want %b", i, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        logic [12:0] exp;
        drive_a(3, 4, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if_a.start_in = 1'b0;
            if_a.abort_in = (k == 6);
            exp = (k <= 6) ? model(k, 3, 4, 1, GUARD_A) : 13'd1;
            n_assert++;
            if (obs_a() !== exp) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %b want %b", k, obs_a(), exp);
            end
        end
        drive_a(3, 4, 1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if_a.start_in = 1'b0;
            if_a.abort_in = 1'b0;
            n_assert++;
            if (obs_a() !== 13'd1) begin
                n_fail++;
                $display("FAIL start_abort cyc %0d: got %b want %b", k, obs_a(), 13'd1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        drive_a(3, 4, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 16) if_a.start_in = 1'b0;
            exp = (k <= 15) ? model(k, 3, 4, 1, GUARD_A) : model(k - 15, 3, 4, 1, GUARD_A);
            n_assert++;
            if (obs_a() !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", k, obs_a(), exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random_bursts();
        logic [12:0] exp;
        int n;
        int p;
        int h;
        int total;
        for (int b = 0; b < 12; b++) begin
            n = int'($urandom_range(1, 5));
            p = int'($urandom_range(2, 12));
            h = int'($urandom_range(1, p - 1));
            total = n * p + GUARD_A;
            drive_a(n, p, h, 1'b1, 1'b0);
            for (int k = 1; k <= total + 1; k++) begin
                @(negedge clk);
                if (k <= total) begin
                    if_a.start_in      = 1'($urandom);
                    if_a.num_pulses_in = 7'($urandom);
                    if_a.period_in     = 11'($urandom);
                    if_a.high_in       = 11'($urandom);
                end else begin
                    if_a.start_in = 1'b0;
                end
                exp = model(k, n, p, h, GUARD_A);
                n_assert++;
                if (obs_a() !== exp) begin
                    n_fail++;
                    $display("FAIL random b%0d n%0d p%0d h%0d cyc %0d: got %b want %b",
                             b, n, p, h, k, obs_a(), exp);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] exp;
        drive_a(3, 4, 3, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        if_a.start_in = 1'b0;
        exp = model(2, 3, 4, 3, GUARD_A);
        n_assert++;
        if (obs_a() !== exp) begin
            n_fail++;
            $display("FAIL async_pre: got %b want %b", obs_a(), exp);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (obs_a() !== 13'd0) begin
            n_fail++;
            $display("FAIL async_drop: got %b want %b", obs_a(), 13'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_a(1, 2, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if_a.start_in = 1'b0;
            exp = model(k, 1, 2, 1, GUARD_A);
            n_assert++;
            if (obs_a() !== exp) begin
                n_fail++;
                $display("FAIL async_restart cyc %0d: got %b want %b", k, obs_a(), exp);
            end
        end
    endtask

    task automatic test_boundary();
        logic [12:0] exp;
        drive_b(1, 2, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if_b.start_in = 1'b0;
            exp = model(k, 1, 2, 1, GUARD_B);
            n_assert++;
            if (obs_b() !== exp) begin
                n_fail++;
                $display("FAIL min_burst cyc %0d: got %b want %b", k, obs_b(), exp);
            end
        end
        drive_b(CMAX_B, PMAX_B, PMAX_B - 1, 1'b1, 1'b0);
        for (int k = 1; k <= CMAX_B * PMAX_B + 3; k++) begin
            @(negedge clk);
            if_b.start_in = 1'b0;
            exp = model(k, CMAX_B, PMAX_B, PMAX_B - 1, GUARD_B);
            n_assert++;
            if (obs_b() !== exp) begin
                n_fail++;
                $display("FAIL max_burst cyc %0d: got %b want %b", k, obs_b(), exp);
            end
        end
        n_assert++;
        if (if_b.pulse_idx_out !== 4'(CMAX_B - 1)) begin
            n_fail++;
            $display("FAIL max_idx: got %0d want %0d", if_b.pulse_idx_out, CMAX_B - 1);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_invalid();
        test_abort();
        test_back_to_back();
        test_random_bursts();
        test_async_reset();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
